// File: rtl/man_pkg.sv
// Shared Manchester line-code definitions for the RFID link (man_mod / man_demod).
package man_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } man_state_e;

  // A logic 1 is sent low-then-high, so its mid-bit edge rises.
  localparam logic MAN_ONE_RISING = 1'b1;
  localparam logic MAN_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/man_demod_if.sv
// Line input and decoded-bit output bundle of the Manchester decoder.
interface man_demod_if;
  logic in_enable;
  logic in_data;
  logic out_data;
  logic out_valid;
  logic out_busy;
  logic out_err;
  logic out_eof;

  modport master (
    output in_enable, in_data,
    input  out_data, out_valid, out_busy, out_err, out_eof
  );

  modport slave (
    input  in_enable, in_data,
    output out_data, out_valid, out_busy, out_err, out_eof
  );
endinterface

// File: rtl/man_edge_sync.sv
// Brings the asynchronous Manchester line into the clk domain and flags its edges.
module man_edge_sync
  import man_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s_p0, s_p1, s_p2;

  // p0/p1: two-flop synchronizer; p2: previous synchronized sample
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p0 <= MAN_IDLE_LEVEL;
      s_p1 <= MAN_IDLE_LEVEL;
      s_p2 <= MAN_IDLE_LEVEL;
    end else begin
      s_p0 <= din;
      s_p1 <= s_p0;
      s_p2 <= s_p1;
    end
  end

  assign level = s_p1;
  assign rise  = s_p1 & ~s_p2;
  assign fall  = ~s_p1 & s_p2;

endmodule

// File: rtl/man_demod.sv
// Manchester decoder: locks to mid-bit edges of an oversampled line and emits NRZ bits,
// with one-cycle strobes for decoded bits, timing violations and end of frame.
module man_demod
  import man_pkg::*;
#(
  parameter int BIT_CYCLES = 8,
  parameter int TOL        = 1
) (
  input logic        clk,
  input logic        rst,
  man_demod_if.slave bus
);

  localparam int HALF = BIT_CYCLES / 2;
  localparam int CW   = $clog2(BIT_CYCLES + TOL + 2);

  localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES + TOL + 1);
  localparam logic [CW-1:0] BND_LO  = CW'(HALF - TOL);
  localparam logic [CW-1:0] BND_HI  = CW'(HALF + TOL);
  localparam logic [CW-1:0] MID_LO  = CW'(BIT_CYCLES - TOL);
  localparam logic [CW-1:0] MID_HI  = CW'(BIT_CYCLES + TOL);
  localparam logic [CW-1:0] ARM_CNT = CW'(BIT_CYCLES);

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ARMED  = 2'(ARMED);
  localparam logic [1:0] ST_LOCKED = 2'(LOCKED);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  logic level, rise, fall;

  man_edge_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.in_data),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n, elapsed;
  logic          bnd, bnd_n;
  logic          busy_q, busy_n;
  logic          valid_q, valid_n, data_q, data_n, err_q, err_n, eof_q, eof_n;
  logic          line_edge, in_mid, in_bnd;

  // The edge being judged is one cycle past the last registered count,
  // so windows are measured against cnt+1 (on-time mid edge == BIT_CYCLES).
  assign elapsed   = sat_inc(cnt);
  assign line_edge = rise | fall;
  assign in_mid    = (elapsed >= MID_LO) && (elapsed <= MID_HI);
  assign in_bnd    = (elapsed >= BND_LO) && (elapsed <= BND_HI);

  always_comb begin
    state_n = state;
    cnt_n   = elapsed;
    bnd_n   = bnd;
    busy_n  = busy_q;
    valid_n = 1'b0;
    data_n  = 1'b0;
    err_n   = 1'b0;
    eof_n   = 1'b0;
    if (!bus.in_enable) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      bnd_n   = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy_n = 1'b0;
          bnd_n  = 1'b0;
          if (level != MAN_IDLE_LEVEL) cnt_n = '0;
          else if (elapsed >= ARM_CNT) state_n = ST_ARMED;
        end
        ST_ARMED: begin
          if (rise) begin
            state_n = ST_LOCKED;
            cnt_n   = '0;
            bnd_n   = 1'b0;
            busy_n  = 1'b1;
          end else if (level != MAN_IDLE_LEVEL) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_LOCKED: begin
          if (line_edge) begin
            if (in_mid) begin
              valid_n = 1'b1;
              data_n  = (level == MAN_ONE_RISING);
              cnt_n   = '0;
              bnd_n   = 1'b0;
            end else if (in_bnd && !bnd) begin
              bnd_n = 1'b1;
            end else begin
              err_n   = 1'b1;
              busy_n  = 1'b0;
              state_n = ST_IDLE;
              cnt_n   = '0;
              bnd_n   = 1'b0;
            end
          end else if (elapsed == CNT_MAX) begin
            eof_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
            cnt_n   = '0;
            bnd_n   = 1'b0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          bnd_n   = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bnd     <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      err_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bnd     <= bnd_n;
      busy_q  <= busy_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      err_q   <= err_n;
      eof_q   <= eof_n;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_busy  = busy_q;
  assign bus.out_err   = err_q;
  assign bus.out_eof   = eof_q;

endmodule

// File: tb/tb_man_demod.sv
// Bench for man_demod: a cycle-accurate Manchester encoder drives the line and
// queues the bit/err/eof events (with their cycle) and busy probes it expects back.
module tb_man_demod;

  localparam int K_NONE  = 0;
  localparam int K_VALID = 1;
  localparam int K_ERR   = 2;
  localparam int K_EOF   = 3;

  typedef struct {
    int   kind;
    logic d;
    int   t;
  } ev_t;

  typedef struct {
    int   t;
    logic b;
  } probe_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_t = 0;

  ev_t    exp_q[$];
  probe_t prb_q[$];

  int jh1[6] = '{4, 4, 3, 5, 4, 4};
  int jh2[6] = '{5, 4, 4, 4, 3, 4};

  man_demod_if bus ();

  man_demod #(
    .BIT_CYCLES (8),
    .TOL        (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [4:0] outs();
    return {bus.out_valid, bus.out_data, bus.out_busy, bus.out_err, bus.out_eof};
  endfunction

  // Scoreboard: every strobe must match the head of the expected-event queue
  always @(negedge clk) begin
    int     kind;
    ev_t    e;
    probe_t p;
    if (bus.out_valid || bus.out_err || bus.out_eof) begin
      kind = bus.out_err ? K_ERR : (bus.out_eof ? K_EOF : K_VALID);
      chk("one_event", 32'(bus.out_valid) + 32'(bus.out_err) + 32'(bus.out_eof), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", kind, K_NONE);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.t);
        if (e.kind == K_VALID) chk("bit", bus.out_data, e.d);
      end
    end
    while (prb_q.size() > 0 && prb_q[0].t <= cyc) begin
      p = prb_q.pop_front();
      if (p.t < cyc) chk("busy_probe_missed", cyc, p.t);
      else chk("busy", bus.out_busy, p.b);
    end
  end

  task automatic push_ev(input int kind, input logic d, input int t);
    ev_t e;
    e.kind = kind;
    e.d    = d;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  task automatic push_busy(input int t, input logic b);
    probe_t p;
    p.t = t;
    p.b = b;
    prb_q.push_back(p);
  endtask

  // Hold the line at lvl for n cycles; t is the cycle of the first change.
  task automatic drive(input logic lvl, input int n, output int t);
    t = cyc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) t = cyc;
      bus.in_data = lvl;
    end
  endtask

  // One Manchester bit; output appears 3 clk edges after the mid-bit change.
  task automatic send_bit(input logic b, input int h1, input int h2, input bit is_start);
    int tm;
    drive(~b, h1, tm);
    drive(b, 1, tm);
    if (is_start) begin
      push_busy(tm + 2, 1'b0);
      push_busy(tm + 3, 1'b1);
    end else begin
      push_ev(K_VALID, b, tm + 3);
      last_t = tm + 3;
    end
    drive(b, h2 - 1, tm);
  endtask

  task automatic send_frame(input int pre, input int n, input logic [63:0] pat, input bit jit,
                            input int tail);
    int tm;
    drive(1'b0, pre, tm);
    if (jit) send_bit(1'b1, jh1[0], jh2[0], 1'b1);
    else send_bit(1'b1, 4, 4, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (jit) send_bit(pat[i], jh1[i+1], jh2[i+1], 1'b0);
      else send_bit(pat[i], 4, 4, 1'b0);
    end
    push_busy(last_t + 9, 1'b1);
    push_ev(K_EOF, 1'b0, last_t + 10);
    push_busy(last_t + 10, 1'b0);
    drive(1'b0, tail, tm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int tm;
    int c;
    rst           = 1'b1;
    bus.in_enable = 1'b1;
    bus.in_data   = 1'b0;

    // reset with a toggling line, then 8 quiet cycles
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_data = ~bus.in_data;
      chk("reset_outputs", outs(), 0);
    end
    @(negedge clk);
    rst         = 1'b0;
    bus.in_data = 1'b0;
    chk("reset_release", outs(), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", outs(), 0);
    end

    // clean frame 1,0,1,1,0 and the same frame with +/-1 edge jitter
    send_frame(10, 5, 64'h0D, 1'b0, 14);
    send_frame(10, 5, 64'h0D, 1'b1, 14);

    // mid-bit edge of the second data bit arrives 2 cycles late
    drive(1'b0, 10, tm);
    send_bit(1'b1, 4, 4, 1'b1);
    send_bit(1'b1, 4, 4, 1'b0);
    drive(1'b1, 6, tm);
    drive(1'b0, 1, tm);
    push_ev(K_ERR, 1'b0, tm + 3);
    push_busy(tm + 3, 1'b0);
    drive(1'b0, 3, tm);
    send_frame(8, 4, 64'h6, 1'b0, 14);

    // drop enable two bits into a frame, re-enable with the line high
    drive(1'b0, 10, tm);
    send_bit(1'b1, 4, 4, 1'b1);
    send_bit(1'b1, 4, 4, 1'b0);
    send_bit(1'b0, 4, 4, 1'b0);
    drive(1'b1, 2, tm);
    @(negedge clk);
    bus.in_enable = 1'b0;
    c = cyc;
    push_busy(c + 1, 1'b0);
    drive(1'b0, 4, tm);
    drive(1'b1, 4, tm);
    drive(1'b0, 3, tm);
    drive(1'b1, 3, tm);
    @(negedge clk);
    bus.in_enable = 1'b1;
    drive(1'b1, 3, tm);
    drive(1'b0, 5, tm);
    drive(1'b1, 2, tm);
    drive(1'b0, 6, tm);
    drive(1'b1, 3, tm);
    send_frame(10, 4, 64'h9, 1'b0, 14);

    // long alternating run
    send_frame(10, 32, 64'h5555_5555, 1'b0, 14);

    // reset in the middle of a bit, then relock
    drive(1'b0, 10, tm);
    send_bit(1'b1, 4, 4, 1'b1);
    send_bit(1'b0, 4, 4, 1'b0);
    send_bit(1'b1, 4, 4, 1'b0);
    drive(1'b0, 2, tm);
    @(negedge clk);
    rst = 1'b1;
    c = cyc;
    push_busy(c + 1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("midframe_reset_outputs", outs(), 0);
    drive(1'b1, 4, tm);
    send_frame(10, 6, 64'h2D, 1'b0, 14);

    repeat (4) @(negedge clk);
    chk("events_drained", exp_q.size(), 0);
    chk("probes_drained", prb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
